// File: rtl/seg_display_arbiter.sv
// Arbitrates the 8-digit display between a fault message, a debug message and live CPU data.
// Optional build macro SEG_ARB_PREEMPT_EN lets a fault request preempt a debug message.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 32'd10_000_000,
  parameter int unsigned BLANK_CYCLES = 32'd1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] acc_data,
  input  logic [15:0] mr_data,
  input  logic        req0,
  input  logic [31:0] msg0,
  input  logic        req1,
  input  logic [31:0] msg1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] disp_data,
  output logic        disp_blank,
  output logic [1:0]  disp_src,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BLANK_IN  = 2'd1,
    S_HOLD      = 2'd2,
    S_BLANK_OUT = 2'd3
  } state_t;

  localparam logic [1:0]  SRC_MSG0   = 2'd0;
  localparam logic [1:0]  SRC_MSG1   = 2'd1;
  localparam logic [1:0]  SRC_LIVE   = 2'd2;
  localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 32'd1);
  localparam bit          BLANK_EN   = (BLANK_CYCLES != 32'd0);
  localparam logic [31:0] BLANK_LOAD = BLANK_EN ? 32'(BLANK_CYCLES - 32'd1) : 32'd0;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] msg_q, msg_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_blank_q, disp_blank_d;
  logic [1:0]  disp_src_q, disp_src_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        busy_q, busy_d;
  logic        preempt_s;
  logic        grant_s;
  logic [31:0] grant_msg_s;
  logic [31:0] live_s;

`ifdef SEG_ARB_PREEMPT_EN
  assign preempt_s = req0 && ((state_q == S_BLANK_IN) || (state_q == S_HOLD)) &&
                     (disp_src_q == SRC_MSG1);
`else
  assign preempt_s = 1'b0;
`endif

  assign grant_s     = ((state_q == S_IDLE) && (req0 || req1)) || preempt_s;
  assign grant_msg_s = req0 ? msg0 : msg1;
  assign live_s      = {mr_data, acc_data};

  // Next-state and next-output logic; the counter is reloaded on every state entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    msg_d        = msg_q;
    disp_data_d  = disp_data_q;
    disp_blank_d = disp_blank_q;
    disp_src_d   = disp_src_q;
    busy_d       = busy_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    if (grant_s) begin
      msg_d        = grant_msg_s;
      disp_data_d  = grant_msg_s;
      ack0_d       = req0;
      ack1_d       = ~req0;
      disp_src_d   = req0 ? SRC_MSG0 : SRC_MSG1;
      busy_d       = 1'b1;
      state_d      = BLANK_EN ? S_BLANK_IN : S_HOLD;
      cnt_d        = BLANK_EN ? BLANK_LOAD : HOLD_LOAD;
      disp_blank_d = BLANK_EN;
    end else begin
      case (state_q)
        S_IDLE: begin
          disp_data_d  = live_s;
          disp_src_d   = SRC_LIVE;
          disp_blank_d = 1'b0;
          busy_d       = 1'b0;
        end
        S_BLANK_IN: begin
          if (cnt_q == 32'd0) begin
            state_d      = S_HOLD;
            cnt_d        = HOLD_LOAD;
            disp_blank_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
          end else if (BLANK_EN) begin
            state_d      = S_BLANK_OUT;
            cnt_d        = BLANK_LOAD;
            disp_blank_d = 1'b1;
            disp_src_d   = SRC_LIVE;
          end else begin
            state_d      = S_IDLE;
            cnt_d        = 32'd0;
            disp_data_d  = live_s;
            disp_src_d   = SRC_LIVE;
            busy_d       = 1'b0;
          end
        end
        S_BLANK_OUT: begin
          if (cnt_q == 32'd0) begin
            state_d      = S_IDLE;
            disp_data_d  = live_s;
            disp_blank_d = 1'b0;
            busy_d       = 1'b0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: begin
          state_d      = S_IDLE;
          cnt_d        = 32'd0;
          disp_data_d  = live_s;
          disp_src_d   = SRC_LIVE;
          disp_blank_d = 1'b0;
          busy_d       = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      msg_q        <= 32'd0;
      disp_data_q  <= 32'd0;
      disp_blank_q <= 1'b0;
      disp_src_q   <= SRC_LIVE;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      msg_q        <= msg_d;
      disp_data_q  <= disp_data_d;
      disp_blank_q <= disp_blank_d;
      disp_src_q   <= disp_src_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign disp_data  = disp_data_q;
  assign disp_blank = disp_blank_q;
  assign disp_src   = disp_src_q;
  assign busy       = busy_q;

endmodule
